// File: rtl/io_pkg.sv
// Frame widths shared by the serial peripheral links (LED chain and 7-segment chain).
package io_pkg;
    localparam int LED_FRAME_W = 16;
    localparam int SEG_FRAME_W = 64;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by an edge-detect flop; all flops reset to the
// wire's idle level so that no edge is reported in the first cycle after reset.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;
endmodule

// File: rtl/spio_rx.sv
// Serial-to-parallel receiver for the LED / 7-segment shift-register links:
// oversamples the link wires, shifts MSB-first on s_clk rises, latches on s_pen rises.
module spio_rx
    import io_pkg::*;
#(
    parameter int WIDTH = LED_FRAME_W,
    parameter int CNT_W = $clog2(WIDTH + 1) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_clk,
    input  logic             s_clrn,
    input  logic             s_pen,
    input  logic             s_sout,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] bit_cnt
);
    logic clk_lvl, clk_rise, clk_fall;
    logic clrn_lvl, clrn_rise, clrn_fall;
    logic pen_lvl, pen_rise, pen_fall;

    sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst(rst), .d_i(s_clk),
        .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_sync_clrn (
        .clk(clk), .rst(rst), .d_i(s_clrn),
        .level_o(clrn_lvl), .rise_o(clrn_rise), .fall_o(clrn_fall)
    );
    sync_edge #(.RST_VAL(1'b0)) u_sync_pen (
        .clk(clk), .rst(rst), .d_i(s_pen),
        .level_o(pen_lvl), .rise_o(pen_rise), .fall_o(pen_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, clk_lvl, clk_fall, clrn_rise, clrn_fall, pen_lvl, pen_fall};

    // Data delay matches the two synchronizer stages so the bit sampled on a
    // detected s_clk rise is the one present at the pin when s_clk rose.
    logic sout_meta_q, sout_sync_q;

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_shift;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        shreg_d   = shreg_q;
        cnt_shift = cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = ferr_q;

        if (!clrn_lvl) begin
            shreg_d   = '0;
            cnt_shift = '0;
        end else if (clk_rise) begin
            shreg_d = {shreg_q[WIDTH-2:0], sout_sync_q};
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_shift = cnt_q + CNT_W'(1);
            end
        end

        cnt_d = cnt_shift;
        // The latch sees this cycle's shift/clear; compare wide so a narrow counter cannot alias WIDTH.
        if (pen_rise) begin
            data_d  = shreg_d;
            valid_d = 1'b1;
            ferr_d  = (32'(cnt_shift) != 32'(WIDTH));
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sout_meta_q <= 1'b0;
            sout_sync_q <= 1'b0;
            shreg_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sout_meta_q <= s_sout;
            sout_sync_q <= sout_meta_q;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign bit_cnt    = cnt_q;
endmodule
